// File: rtl/event_processor_if.sv
// event_processor_if: game FSM <-> event processor handshake and display status bundle
interface event_processor_if;
  logic [3:0] event_flag;
  logic [3:0] p1_pos;
  logic [3:0] p2_pos;
  logic turn;
  logic event_end_tick;
  logic event_active;
  logic [3:0] event_code;
  logic event_player;
  logic [15:0] event_led;
  modport master (
    output event_flag, p1_pos, p2_pos, turn,
    input event_end_tick, event_active, event_code, event_player, event_led
  );
  modport slave (
    input event_flag, p1_pos, p2_pos, turn,
    output event_end_tick, event_active, event_code, event_player, event_led
  );
endinterface

// File: rtl/event_processor.sv
// event_processor: settles the board snapshot, runs timed event effects with LED animation, pulses end tick
module event_processor #(
  parameter int unsigned EVT_SEC = 100_000_000,
  parameter int unsigned STEP_CYC = 25_000_000,
  parameter int unsigned SETTLE_CYC = 2
) (
  input logic clk,
  input logic reset,
  event_processor_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_RUN, S_DONE, S_WIN} state_t;
  state_t state_q, state_d;
  logic [11:0] snap, snap_q, snap_d, prev_q;
  logic [31:0] stable_cnt_q, stable_cnt_d, sec_cnt_q, sec_cnt_d, step_cnt_q, step_cnt_d;
  logic [7:0] rot_q, rot_d;
  logic [15:0] win_q, win_d;
  logic [3:0] code_q, code_d;
  logic player_q, player_d;
  logic [2:0] dur_sec;
  logic [63:0] target;
  logic step_wrap, settled;
  assign snap = {bus.event_flag, bus.p1_pos, bus.p2_pos};
  assign step_wrap = step_cnt_q == 32'(STEP_CYC - 1);
  assign settled = snap == prev_q && stable_cnt_q == 32'(SETTLE_CYC - 1);
  assign bus.event_active = state_q == S_RUN || state_q == S_WIN;
  assign bus.event_end_tick = state_q == S_DONE;
  assign bus.event_code = code_q;
  assign bus.event_player = player_q;
  assign bus.event_led = state_q == S_RUN ? (player_q ? {8'h00, rot_q} : {rot_q, 8'h00}) :
                         state_q == S_WIN ? win_q : 16'h0000;
  // event duration in seconds and the full-width cycle target it implies
  always_comb begin
    dur_sec = code_q == 4'd2 ? 3'd2 : code_q == 4'd3 ? 3'd1 : code_q == 4'd4 ? 3'd2 :
              (code_q == 4'd6 || code_q == 4'd8) ? 3'd3 : 3'd0;
    target = 64'(dur_sec) * 64'(EVT_SEC);
  end
  // next-state: settle the snapshot, then time the effect and advance the animation
  always_comb begin
    state_d = state_q;
    snap_d = snap_q;
    stable_cnt_d = stable_cnt_q;
    sec_cnt_d = sec_cnt_q;
    step_cnt_d = step_cnt_q;
    rot_d = rot_q;
    win_d = win_q;
    code_d = code_q;
    player_d = player_q;
    case (state_q)
      S_IDLE: begin
        state_d = snap != snap_q ? S_SETTLE : S_IDLE;
        stable_cnt_d = 32'd0;
      end
      S_SETTLE: begin
        stable_cnt_d = snap != prev_q ? 32'd0 : stable_cnt_q + 32'd1;
        if (settled) begin
          snap_d = snap;
          state_d = bus.event_flag == 4'd0 ? S_IDLE : bus.event_flag == 4'd10 ? S_WIN : S_RUN;
          if (bus.event_flag != 4'd0) begin
            code_d = bus.event_flag;
            player_d = bus.turn;
            sec_cnt_d = 32'd0;
            step_cnt_d = 32'd0;
            rot_d = 8'h01;
            win_d = 16'hF0F0;
          end
        end
      end
      S_RUN: begin
        sec_cnt_d = sec_cnt_q + 32'd1;
        step_cnt_d = step_wrap ? 32'd0 : step_cnt_q + 32'd1;
        rot_d = step_wrap ? {rot_q[6:0], rot_q[7]} : rot_q;
        state_d = {32'd0, sec_cnt_q} + 64'd1 >= target ? S_DONE : S_RUN;
      end
      S_DONE: state_d = S_IDLE;
      S_WIN: begin
        step_cnt_d = step_wrap ? 32'd0 : step_cnt_q + 32'd1;
        win_d = step_wrap ? ~win_q : win_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and datapath registers; prev_q tracks last cycle's live snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      snap_q <= '0;
      prev_q <= '0;
      stable_cnt_q <= '0;
      sec_cnt_q <= '0;
      step_cnt_q <= '0;
      rot_q <= '0;
      win_q <= '0;
      code_q <= '0;
      player_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q <= snap_d;
      prev_q <= snap;
      stable_cnt_q <= stable_cnt_d;
      sec_cnt_q <= sec_cnt_d;
      step_cnt_q <= step_cnt_d;
      rot_q <= rot_d;
      win_q <= win_d;
      code_q <= code_d;
      player_q <= player_d;
    end
  end
endmodule

// File: tb/tb_event_processor.sv
// tb_event_processor: table vectors, corner sequences and random stimulus against a reference model
module tb_event_processor;
  localparam int EVT = 8;
  localparam int STEP = 2;
  localparam int SETTLE = 2;
  typedef struct {
    logic [3:0] f;
    logic [3:0] a;
    logic [3:0] b;
    logic t;
    int act;
    int ticks;
    logic [3:0] code;
    logic [15:0] led0;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  event_processor_if bus();
  event_processor #(.EVT_SEC(EVT), .STEP_CYC(STEP), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int dur_tbl[16] = '{0, 0, 2, 1, 2, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0};
  logic [11:0] m_stored, m_prev;
  bit m_settling, m_win, m_done;
  int m_stable, m_left, m_elapsed;
  logic [3:0] m_code;
  logic m_player;
  int act_cnt, tick_cnt;
  bit seen;
  logic [15:0] first_led;
  vec_t tbl[9];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] model_led();
    logic [15:0] r;
    r = 16'(1) << ((m_elapsed / STEP) % 8);
    if (m_win) return ((m_elapsed / STEP) % 2) != 0 ? 16'h0F0F : 16'hF0F0;
    if (m_left > 0) return m_player ? r : r << 8;
    return 16'h0000;
  endfunction
  task automatic model_tick();
    logic [11:0] s;
    bit nt;
    s = {bus.event_flag, bus.p1_pos, bus.p2_pos};
    nt = 0;
    if (reset) begin
      m_stored = '0; m_prev = '0; m_settling = 0; m_win = 0; m_done = 0;
      m_stable = 0; m_left = 0; m_elapsed = 0; m_code = '0; m_player = 0;
      return;
    end
    if (m_win) m_elapsed++;
    else if (m_left > 0) begin
      m_left--;
      m_elapsed++;
      if (m_left == 0) nt = 1;
    end else if (m_done) begin
    end else if (!m_settling) begin
      if (s != m_stored) begin
        m_settling = 1;
        m_stable = 0;
      end
    end else if (s != m_prev) m_stable = 0;
    else if (m_stable == SETTLE - 1) begin
      m_settling = 0;
      m_stored = s;
      if (s[11:8] != 0) begin
        m_code = s[11:8];
        m_player = bus.turn;
        m_elapsed = 0;
        if (s[11:8] == 10) m_win = 1;
        else m_left = dur_tbl[s[11:8]] * EVT > 0 ? dur_tbl[s[11:8]] * EVT : 1;
      end
    end else m_stable++;
    m_done = nt;
    m_prev = s;
  endtask
  task automatic cyc();
    @(posedge clk);
    model_tick();
    #1;
    chk("active", 32'(bus.event_active), 32'(m_win || m_left > 0));
    chk("end_tick", 32'(bus.event_end_tick), 32'(m_done));
    chk("code", 32'(bus.event_code), 32'(m_code));
    chk("player", 32'(bus.event_player), 32'(m_player));
    chk("led", 32'(bus.event_led), 32'(model_led()));
    if (bus.event_active && !seen) begin
      seen = 1;
      first_led = bus.event_led;
    end
    act_cnt += int'(bus.event_active);
    tick_cnt += int'(bus.event_end_tick);
  endtask
  task automatic window(int n);
    act_cnt = 0;
    tick_cnt = 0;
    seen = 0;
    first_led = '0;
    repeat (n) cyc();
  endtask
  task automatic set_in(logic [3:0] f, logic [3:0] a, logic [3:0] b, logic t);
    bus.event_flag = f;
    bus.p1_pos = a;
    bus.p2_pos = b;
    bus.turn = t;
  endtask
  task automatic chk_zero(string name);
    chk({name, "_active"}, 32'(bus.event_active), 0);
    chk({name, "_tick"}, 32'(bus.event_end_tick), 0);
    chk({name, "_code"}, 32'(bus.event_code), 0);
    chk({name, "_player"}, 32'(bus.event_player), 0);
    chk({name, "_led"}, 32'(bus.event_led), 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] codes[10];
    codes = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd1, 4'd15, 4'd0};
    tbl[0] = '{4'd2, 4'd2, 4'd0, 1'b0, 16, 1, 4'd2, 16'h0100};
    tbl[1] = '{4'd3, 4'd2, 4'd4, 1'b1, 8, 1, 4'd3, 16'h0001};
    tbl[2] = '{4'd0, 4'd3, 4'd4, 1'b0, 0, 0, 4'd3, 16'h0000};
    tbl[3] = '{4'd6, 4'd3, 4'd6, 1'b0, 24, 1, 4'd6, 16'h0100};
    tbl[4] = '{4'd4, 4'd7, 4'd6, 1'b1, 16, 1, 4'd4, 16'h0001};
    tbl[5] = '{4'd8, 4'd8, 4'd6, 1'b0, 24, 1, 4'd8, 16'h0100};
    tbl[6] = '{4'd5, 4'd9, 4'd6, 1'b1, 1, 1, 4'd5, 16'h0001};
    tbl[7] = '{4'd5, 4'd9, 4'd6, 1'b0, 0, 0, 4'd5, 16'h0000};
    tbl[8] = '{4'd0, 4'd0, 4'd0, 1'b0, 0, 0, 4'd5, 16'h0000};
    set_in(0, 0, 0, 0);
    reset = 1;
    repeat (2) cyc();
    chk_zero("reset");
    reset = 0;
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].t);
      window(40);
      chk($sformatf("tbl%0d_active_cycles", i), act_cnt, tbl[i].act);
      chk($sformatf("tbl%0d_ticks", i), tick_cnt, tbl[i].ticks);
      chk($sformatf("tbl%0d_code", i), 32'(bus.event_code), 32'(tbl[i].code));
      chk($sformatf("tbl%0d_first_led", i), 32'(first_led), 32'(tbl[i].led0));
    end
    set_in(2, 2, 0, 0);
    window(40);
    chk("glitch_pre_active", act_cnt, 16);
    act_cnt = 0;
    tick_cnt = 0;
    set_in(2, 5, 0, 0);
    cyc();
    set_in(0, 5, 0, 0);
    repeat (40) cyc();
    chk("glitch_active", act_cnt, 0);
    chk("glitch_ticks", tick_cnt, 0);
    set_in(2, 1, 2, 0);
    window(140);
    chk("hold_active", act_cnt, 16);
    chk("hold_ticks", tick_cnt, 1);
    set_in(6, 1, 6, 0);
    window(40);
    chk("move_active", act_cnt, 24);
    chk("move_ticks", tick_cnt, 1);
    set_in(10, 3, 3, 1);
    window(1000);
    chk("win_active", act_cnt, 998);
    chk("win_ticks", tick_cnt, 0);
    chk("win_code", 32'(bus.event_code), 10);
    reset = 1;
    set_in(0, 0, 0, 0);
    cyc();
    chk_zero("win_reset");
    reset = 0;
    window(20);
    chk("post_win_active", act_cnt, 0);
    set_in(8, 4, 4, 0);
    window(0);
    for (int i = 0; i < 10 && !seen; i++) cyc();
    chk("midrun_started", 32'(seen), 1);
    repeat (4) cyc();
    reset = 1;
    cyc();
    chk_zero("midrun_reset");
    reset = 0;
    window(40);
    chk("retrigger_active", act_cnt, 24);
    chk("retrigger_ticks", tick_cnt, 1);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.event_flag = $urandom_range(0, 39) == 0 ? 4'd10 : codes[$urandom_range(0, 9)];
          1: bus.p1_pos = 4'($urandom_range(0, 15));
          2: bus.p2_pos = 4'($urandom_range(0, 15));
          default: bus.turn = 1'($urandom_range(0, 1));
        endcase
      end
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/event_processor.md
Name: event_processor

Overview:
- Responder side of the board-event handshake: watches the game FSM's `event_flag`, `p1_pos`, `p2_pos` and `turn`, and runs a timed event effect.
- Returns a one-cycle `event_end_tick` when the effect finishes so the game FSM can advance the turn.
- Drives a 16-LED event animation and status outputs for the display path.
- The win event (code 10) never ends; it is held until reset.

Parameters:
- EVT_SEC, 100_000_000, clock cycles per event second.
- STEP_CYC, 25_000_000, clock cycles per animation step.
- SETTLE_CYC, 2, consecutive cycles the input snapshot must stay unchanged before it is evaluated (minimum 2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- event_flag  input  4  event code from game FSM (0 = none; 2,3,4,6,8 = board events; 10 = win)
- p1_pos  input  4  player 1 position
- p2_pos  input  4  player 2 position
- turn  input  1  current player (0 = P1, 1 = P2)
- event_end_tick  output  1  one-cycle pulse, event finished
- event_active  output  1  high while an event effect runs (including the win hold)
- event_code  output  4  code of the running or last event
- event_player  output  1  turn latched at event start
- event_led  output  16  animation pattern

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high; `reset` is sampled only on the `clk` rising edge.
- Reset values:
  - all outputs 0;
  - snapshot register {flag, p1, p2} = 0;
  - all counters 0;
  - state S_IDLE.
- Snapshot: the 12-bit concatenation {event_flag, p1_pos, p2_pos}. `turn` is excluded.
- States:
  - S_IDLE: if the live snapshot differs from the stored snapshot, go to S_SETTLE with stable_cnt = 0.
  - S_SETTLE:
    - If the live snapshot changes from the previous cycle, reset stable_cnt to 0.
    - Otherwise increment stable_cnt.
    - When stable_cnt reaches SETTLE_CYC-1 and the snapshot is unchanged:
      - store the snapshot;
      - if event_flag == 0, go to S_IDLE (no event);
      - otherwise latch event_code = event_flag and event_player = turn, then go to S_RUN (code 10 goes to S_WIN).
    - Settling is required because position and flag update on successive cycles and must not trigger a false start.
  - S_RUN:
    - event_active = 1.
    - Duration D seconds: code 2 → 2, code 3 → 1, code 4 → 2, code 6 → 3, code 8 → 3, any other nonzero code → 0.
    - Stay exactly D*EVT_SEC cycles, then go to S_DONE.
    - A code with D = 0 passes straight through: one cycle in S_RUN, then S_DONE.
    - Input changes are ignored during S_RUN.
  - S_DONE: one cycle. event_end_tick = 1, event_active = 0, event_led = 0. Then S_IDLE.
  - S_WIN: event_active = 1. Held until reset; no end tick is ever issued.
- Animation (S_RUN and S_WIN):
  - step_cnt wraps at STEP_CYC-1; on wrap, advance the pattern.
  - S_RUN: rot8 starts at 8'h01 on entry and rotates left by 1 each step (8'h80 wraps to 8'h01).
    - event_player = 0: event_led = {rot8, 8'h00}.
    - event_player = 1: event_led = {8'h00, rot8}.
  - S_WIN: event_led starts at 16'hF0F0 and toggles between 16'hF0F0 and 16'h0F0F each step.
- Retrigger rules:
  - After S_DONE the stored snapshot equals the evaluated one, so a flag left at the same value with unchanged positions does not retrigger.
  - A new dice move changes the positions and does retrigger, even if the code repeats.
  - Changes arriving during S_RUN are seen in S_IDLE and evaluated normally.
- Counters are 32-bit. The seconds count compares against D*EVT_SEC computed at full width (no truncation).
- Reset in any state, including mid-S_RUN or S_WIN, returns to the reset values the next cycle; no end tick is emitted.

Test Plan (EVT_SEC=8, STEP_CYC=2, SETTLE_CYC=2):
- Flag 2 with p1_pos=2, turn=0, held stable → event_active rises after settling, stays high exactly 16 cycles, then event_end_tick pulses for 1 cycle. event_code=2, event_player=0. event_led steps through 16'h0100, 16'h0200, …
- Position change to 5 one cycle before flag changes 2→0 → no event starts and no end tick; the glitch must not start an event.
- Flag 3, turn=1 → event_active high for 8 cycles, tick follows. event_led lower byte runs 8'h01, 8'h02, 8'h04, 8'h08.
- Event 2 completes, snapshot left unchanged for 100 cycles → no second event. Then p2_pos 2→6 with flag 6 → a new 24-cycle event runs.
- Flag 10 → event_active stays high, event_led alternates F0F0/0F0F every 2 cycles, no tick after 1000 cycles. Reset then clears all outputs.
- Reset asserted at cycle 5 of a flag-8 event → all outputs 0 on the next cycle and no tick. The same snapshot after reset retriggers the event.
